// File: rtl/serial_cmd_slave.sv
// serial_cmd_slave
// ----------------------------------------------------------------------------
// Deserialises host commands from the FX2 3-wire serial bus (sclk/sen/sdi)
// into the master_clk domain. The bus inputs are oversampled on master_clk;
// there is no other clock in this block.
//
// Frame (MSB first): bit 0 = R/W (1 = read), bits 1-7 = address,
// bits 8-39 = write data (ignored on reads).
//   - A complete write frame produces one serial_strobe cycle carrying
//     serial_addr/serial_data.
//   - A read frame drives the selected readback word on sdo while sdo_en is
//     high.
//   - Short frames and overrun frames pulse frame_error.
//
// Ports
//   master_clk      system clock, at least 8x the sclk frequency
//   reset_n         asynchronous active-low reset
//   sclk, sen, sdi  host serial bus; asynchronous to master_clk
//   sdo, sdo_en     serial read data and its tristate enable
//   readback_0..3   readback words selectable by read address 0..3
//   serial_addr     committed write address; holds between commits
//   serial_data     committed write data; holds between commits
//   serial_strobe   one-cycle write commit pulse
//   frame_error     one-cycle pulse on a malformed frame
//   busy            high while a frame is in progress
//   dbg_state       current FSM state, for observation only
//
// Handshake: there is no back-pressure. serial_strobe is a single-cycle
// valid. serial_addr/serial_data are updated in the same cycle that
// serial_strobe is high and are stable at every other time, so a consumer
// only needs to sample them while serial_strobe is high.
// ----------------------------------------------------------------------------
module serial_cmd_slave #(
  parameter int FRAME_BITS   = 40,
  parameter int NUM_READBACK = 4
) (
  input  logic        master_clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        sen,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_en,
  input  logic [31:0] readback_0,
  input  logic [31:0] readback_1,
  input  logic [31:0] readback_2,
  input  logic [31:0] readback_3,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        serial_strobe,
  output logic        frame_error,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    FULL  = 3'd4
  } state_t;

  localparam logic [5:0] HDR_CNT  = 6'd8;
  localparam logic [5:0] LAST_CNT = 6'(FRAME_BITS);

  // Synchronisers. The third stage on sclk and sen is for edge detection.
  logic sclk_s1, sclk_s2, sclk_s3;
  logic sen_s1, sen_s2, sen_s3;
  logic sdi_s1, sdi_s2;
  logic sclk_rise, sclk_fall, sen_rise, sen_fall;

  // Frames are accepted only after sen has been seen low once since reset.
  // The synchroniser stages come out of reset at 0, so a sen that is already
  // high would otherwise look like a fresh rising edge.
  logic [1:0] sync_fill;
  logic       armed;

  state_t                state, state_next;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [31:0]           out_reg;
  logic [31:0]           rb_sel;
  logic                  rw_flag;
  logic                  skip_fall;
  logic                  overrun;

  logic frame_start, commit_go, error_go, load_out;
  logic commit_pend, error_pend;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign sen_rise  = sen_s2 & ~sen_s3;
  assign sen_fall  = ~sen_s2 & sen_s3;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      sen_s1    <= 1'b0;
      sen_s2    <= 1'b0;
      sen_s3    <= 1'b0;
      sdi_s1    <= 1'b0;
      sdi_s2    <= 1'b0;
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sen_s1  <= sen;
      sen_s2  <= sen_s1;
      sen_s3  <= sen_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      // sen_s2 reflects the real pin only once two edges have passed.
      if (sync_fill == 2'd2 && !sen_s2) armed <= 1'b1;
    end
  end

  // Readback selection from the address header (low 7 bits after 8 shifts).
  always_comb begin
    rb_sel = '0;
    if (shift_reg[6:0] < 7'(NUM_READBACK)) begin
      case (shift_reg[1:0])
        2'd0:    rb_sel = readback_0;
        2'd1:    rb_sel = readback_1;
        2'd2:    rb_sel = readback_2;
        default: rb_sel = readback_3;
      endcase
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    commit_go   = 1'b0;
    error_go    = 1'b0;
    load_out    = 1'b0;
    if (state != IDLE && sen_fall) begin
      state_next = IDLE;
      if (state == FULL && !overrun) begin
        // Complete frame: writes commit, reads end silently.
        commit_go = ~rw_flag;
      end else begin
        error_go = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (sen_rise && armed) begin
            frame_start = 1'b1;
            state_next  = HDR;
          end
        end
        HDR: begin
          if (bit_cnt == HDR_CNT) begin
            if (shift_reg[7]) begin
              load_out   = 1'b1;
              state_next = RDATA;
            end else begin
              state_next = WDATA;
            end
          end
        end
        WDATA:   if (bit_cnt == LAST_CNT) state_next = FULL;
        RDATA:   if (bit_cnt == LAST_CNT) state_next = FULL;
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      out_reg   <= '0;
      rw_flag   <= 1'b0;
      skip_fall <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_start) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      out_reg   <= '0;
      rw_flag   <= 1'b0;
      skip_fall <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sclk_rise && sen_s2 && (state == HDR || state == WDATA || state == RDATA))
        bit_cnt <= bit_cnt + 6'd1;
      if (sclk_rise && (state == HDR || state == WDATA))
        shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s2};
      if (sclk_rise && state == FULL)
        overrun <= 1'b1;
      if (load_out) begin
        out_reg   <= rb_sel;
        rw_flag   <= 1'b1;
        // The load lands while bit 7 is still high; its falling edge must
        // not shift, so the host sees bit 31 during bit 8.
        skip_fall <= 1'b1;
      end else if (state == RDATA && sclk_fall) begin
        if (skip_fall) skip_fall <= 1'b0;
        else           out_reg   <= {out_reg[30:0], 1'b0};
      end
    end
  end

  // Commit one cycle after the FSM sees sen_fall. The frame contents stay in
  // shift_reg because nothing shifts in IDLE.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_pend   <= 1'b0;
      error_pend    <= 1'b0;
      serial_strobe <= 1'b0;
      frame_error   <= 1'b0;
      serial_addr   <= '0;
      serial_data   <= '0;
    end else begin
      commit_pend   <= commit_go;
      error_pend    <= error_go;
      serial_strobe <= commit_pend;
      frame_error   <= error_pend;
      if (commit_pend) begin
        serial_addr <= shift_reg[FRAME_BITS-2 -: 7];
        serial_data <= shift_reg[31:0];
      end
    end
  end

  assign sdo_en    = (state == RDATA);
  assign sdo       = sdo_en & out_reg[31];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_cmd_slave.sv
module tb_serial_cmd_slave;

  logic        master_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic        sclk       = 1'b0;
  logic        sen        = 1'b0;
  logic        sdi        = 1'b0;
  logic        sdo, sdo_en;
  logic [31:0] rb_arr [4];
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe, frame_error, busy;
  logic [2:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard: expected and observed commits as {addr, data}.
  logic [38:0] exp_q[$];
  logic [38:0] got_q[$];
  int          err_seen = 0;

  serial_cmd_slave dut (
    .master_clk   (master_clk),
    .reset_n      (reset_n),
    .sclk         (sclk),
    .sen          (sen),
    .sdi          (sdi),
    .sdo          (sdo),
    .sdo_en       (sdo_en),
    .readback_0   (rb_arr[0]),
    .readback_1   (rb_arr[1]),
    .readback_2   (rb_arr[2]),
    .readback_3   (rb_arr[3]),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .frame_error  (frame_error),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  always #5 master_clk = ~master_clk;

  // Commit / error monitor
  always @(negedge master_clk) begin
    if (serial_strobe) got_q.push_back({serial_addr, serial_data});
    if (frame_error)   err_seen++;
  end

  // Reference model: readback word returned for a read address.
  function automatic logic [31:0] model_rb(input logic [6:0] a);
    if (a < 7'd4) return rb_arr[a[1:0]];
    return 32'h0;
  endfunction

  // Frame bits aligned so the first bit sent is bits[nbits-1].
  function automatic logic [63:0] make_bits(input logic rw, input logic [6:0] a,
                                            input logic [31:0] d, input int nbits);
    logic [63:0] f;
    f = {24'h0, rw, a, d};
    if (nbits >= 40) return (f << (nbits - 40)) | 64'((64'h1 << (nbits - 40)) - 64'h1);
    return f >> (40 - nbits);
  endfunction

  // Host driver: SCLK = master_clk/16. Optional reset pulse before bit rst_at.
  // Checks busy/sdo_en/sdo at every SCLK rise and collects the read word.
  task automatic host_frame(input logic [63:0] bits, input int nbits, input int rst_at,
                            output logic [31:0] rd_word, output int proto_bad);
    logic rw, exp_en, exp_busy;
    rw        = bits[nbits-1];
    rd_word   = '0;
    proto_bad = 0;
    sen       = 1'b1;
    repeat (8) @(negedge master_clk);
    for (int i = 0; i < nbits; i++) begin
      sdi = bits[nbits-1-i];
      if (i == rst_at) begin
        reset_n = 1'b0;
        repeat (3) @(negedge master_clk);
        reset_n = 1'b1;
      end
      repeat (8) @(negedge master_clk);
      exp_busy = (rst_at < 0) || (i < rst_at);
      exp_en   = rw && (rst_at < 0) && (i >= 8) && (i < 40);
      if (busy !== exp_busy || sdo_en !== exp_en) proto_bad++;
      if (!exp_en && sdo !== 1'b0) proto_bad++;
      if (i >= 8 && i < 40) rd_word = {rd_word[30:0], sdo};
      sclk = 1'b1;
      repeat (8) @(negedge master_clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge master_clk);
    sen = 1'b0;
  endtask

  // Records strobe/error on the 8 negedges following the sen fall.
  task automatic watch_window(output logic [7:0] strobe_pat, output logic [7:0] err_pat,
                              output logic [38:0] at_strobe);
    strobe_pat = '0;
    err_pat    = '0;
    at_strobe  = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge master_clk);
      strobe_pat[k] = serial_strobe;
      err_pat[k]    = frame_error;
      if (serial_strobe) at_strobe = {serial_addr, serial_data};
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge master_clk);
    tests_run++;
    if ({serial_strobe, frame_error, busy, sdo, sdo_en, serial_addr, serial_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_in: outputs %b/%b/%b/%b/%b %h %h, required all zero",
               serial_strobe, frame_error, busy, sdo, sdo_en, serial_addr, serial_data);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge master_clk);
    tests_run++;
    if ({serial_strobe, frame_error, busy, sdo, sdo_en, serial_addr, serial_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_after: outputs %b/%b/%b/%b/%b %h %h, required all zero",
               serial_strobe, frame_error, busy, sdo, sdo_en, serial_addr, serial_data);
    end
  endtask

  task automatic test_write();
    logic [31:0] rd; int pb; logic [7:0] sp, ep; logic [38:0] v;
    host_frame(make_bits(1'b0, 7'h05, 32'hDEADBEEF, 40), 40, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if (sp !== 8'b0000_1000) begin
      tests_failed++;
      $display("FAIL write_strobe_timing: got %b required %b", sp, 8'b0000_1000);
    end
    tests_run++;
    if (v !== {7'h05, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL write_value: got %h required %h", v, {7'h05, 32'hDEADBEEF});
    end
    tests_run++;
    if (ep !== 8'h00 || pb !== 0) begin
      tests_failed++;
      $display("FAIL write_error_proto: err %b proto %0d required 0/0", ep, pb);
    end
    tests_run++;
    if ({serial_addr, serial_data} !== {7'h05, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL write_hold: got %h required %h", {serial_addr, serial_data}, {7'h05, 32'hDEADBEEF});
    end
  endtask

  task automatic test_read();
    logic [31:0] rd; int pb; logic [7:0] sp, ep; logic [38:0] v;
    rb_arr[0] = 32'hA0A0A0A0; rb_arr[1] = 32'hB1B1B1B1;
    rb_arr[2] = 32'h12345678; rb_arr[3] = 32'hC3C3C3C3;
    host_frame(make_bits(1'b1, 7'h02, 32'h0, 40), 40, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if (rd !== model_rb(7'h02)) begin
      tests_failed++;
      $display("FAIL read_word: got %h required %h", rd, model_rb(7'h02));
    end
    tests_run++;
    if (pb !== 0) begin
      tests_failed++;
      $display("FAIL read_sdo_en: %0d protocol violations, required 0", pb);
    end
    tests_run++;
    if (sp !== 8'h00 || ep !== 8'h00) begin
      tests_failed++;
      $display("FAIL read_no_strobe: strobe %b err %b required 0/0", sp, ep);
    end
  endtask

  task automatic test_short();
    logic [31:0] rd; int pb; logic [7:0] sp, ep; logic [38:0] v;
    host_frame(make_bits(1'b0, 7'h33, 32'hCAFEF00D, 20), 20, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if ($countones(ep) != 1 || sp !== 8'h00) begin
      tests_failed++;
      $display("FAIL short_error: err %b strobe %b required one error pulse, no strobe", ep, sp);
    end
    tests_run++;
    if ({serial_addr, serial_data} !== {7'h05, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL short_hold: got %h required %h", {serial_addr, serial_data}, {7'h05, 32'hDEADBEEF});
    end
  endtask

  task automatic test_overrun_oob();
    logic [31:0] rd; int pb; logic [7:0] sp, ep; logic [38:0] v;
    host_frame(make_bits(1'b0, 7'h44, 32'h11223344, 41), 41, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if ($countones(ep) != 1 || sp !== 8'h00) begin
      tests_failed++;
      $display("FAIL overrun_error: err %b strobe %b required one error pulse, no strobe", ep, sp);
    end
    host_frame(make_bits(1'b1, 7'h7F, 32'h0, 40), 40, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if (rd !== model_rb(7'h7F)) begin
      tests_failed++;
      $display("FAIL oob_read_word: got %h required %h", rd, model_rb(7'h7F));
    end
    tests_run++;
    if (sp !== 8'h00 || ep !== 8'h00 || pb !== 0) begin
      tests_failed++;
      $display("FAIL oob_read_quiet: strobe %b err %b proto %0d required 0/0/0", sp, ep, pb);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int pb; logic [7:0] sp, ep; logic [38:0] v;
    host_frame(make_bits(1'b0, 7'h22, 32'h55AA55AA, 40), 40, 25, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if (sp !== 8'h00 || ep !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: strobe %b err %b required 0/0", sp, ep);
    end
    tests_run++;
    if (pb !== 0 || {serial_addr, serial_data} !== 39'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: proto %0d regs %h required 0/0", pb, {serial_addr, serial_data});
    end
    host_frame(make_bits(1'b0, 7'h01, 32'h00000003, 40), 40, -1, rd, pb);
    watch_window(sp, ep, v);
    tests_run++;
    if (sp !== 8'b0000_1000 || v !== {7'h01, 32'h3} || ep !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_next: strobe %b value %h err %b required %b %h 0",
               sp, v, ep, 8'b0000_1000, {7'h01, 32'h3});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int pb; int err_base; logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    got_q.delete(); exp_q.delete();
    err_base = err_seen;
    exp_q.push_back({7'h0A, d0});
    exp_q.push_back({7'h0B, d1});
    host_frame(make_bits(1'b0, 7'h0A, d0, 40), 40, -1, rd, pb);
    repeat (4) @(negedge master_clk);
    host_frame(make_bits(1'b0, 7'h0B, d1, 40), 40, -1, rd, pb);
    repeat (10) @(negedge master_clk);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [38:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL b2b_value: got %h required %h", g, e);
      end
    end
    tests_run++;
    if (err_seen - err_base != 0) begin
      tests_failed++;
      $display("FAIL b2b_error: got %0d error pulses required 0", err_seen - err_base);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; int pb; int err_base; int exp_err;
    got_q.delete(); exp_q.delete();
    err_base = err_seen;
    exp_err  = 0;
    for (int j = 0; j < 4; j++) rb_arr[j] = $urandom;
    for (int n = 0; n < 10; n++) begin
      logic rw; logic [6:0] a; logic [31:0] d; int len; int pick;
      rw   = ($urandom_range(0, 2) == 0);
      a    = rw ? (($urandom_range(0, 3) == 0) ? 7'($urandom_range(4, 127)) : 7'($urandom_range(0, 3)))
                : 7'($urandom_range(0, 127));
      d    = $urandom;
      pick = $urandom_range(0, 9);
      len  = (pick == 0) ? $urandom_range(9, 39) : (pick == 1) ? $urandom_range(41, 42) : 40;
      if (len == 40 && !rw) exp_q.push_back({a, d});
      if (len != 40) exp_err++;
      host_frame(make_bits(rw, a, d, len), len, -1, rd, pb);
      if (rw && len >= 40) begin
        tests_run++;
        if (rd !== model_rb(a)) begin
          tests_failed++;
          $display("FAIL rand_read_word: addr %h got %h required %h", a, rd, model_rb(a));
        end
      end
      if (len >= 40) begin
        tests_run++;
        if (pb !== 0) begin
          tests_failed++;
          $display("FAIL rand_proto: frame %0d had %0d violations required 0", n, pb);
        end
      end
      repeat ($urandom_range(4, 12)) @(negedge master_clk);
    end
    repeat (10) @(negedge master_clk);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d strobes required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [38:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("FAIL rand_value: got %h required %h", g, e);
      end
    end
    tests_run++;
    if (err_seen - err_base != exp_err) begin
      tests_failed++;
      $display("FAIL rand_error: got %0d error pulses required %0d", err_seen - err_base, exp_err);
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) rb_arr[j] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_short();
    test_overrun_oob();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_cmd_slave.md
Name: serial_cmd_slave

Overview:
- Front end of the control path: deserialises host commands from the FX2 3-wire serial bus into the master_clk domain.
- Write frames emit the serial_addr / serial_data / serial_strobe triplet consumed by every setting_reg in the design.
- Read frames shift a selected readback word back to the host.
- All serial-bus inputs are oversampled on master_clk; the block has no clock other than master_clk.

Parameters:
- FRAME_BITS, 40, total bits per frame: 1 R/W + 7 address + 32 data.
- NUM_READBACK, 4, number of readback words selectable.

Ports:
- master_clk  input  1  system clock. Must be >= 8x SCLK frequency.
- reset_n  input  1  asynchronous, active-low reset.
- sclk  input  1  host serial clock, asynchronous.
- sen  input  1  host frame enable, active high, asynchronous.
- sdi  input  1  host serial data in, asynchronous.
- sdo  output  1  serial data to host.
- sdo_en  output  1  tristate enable for sdo.
- readback_0..readback_3  input  32 each  readback words.
- serial_addr  output  7  committed write address.
- serial_data  output  32  committed write data.
- serial_strobe  output  1  one-cycle write commit pulse.
- frame_error  output  1  one-cycle pulse on a malformed frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: all outputs and internal registers clear to 0. State is IDLE.
- Synchronisation:
  - sclk, sen and sdi each pass through a 2-FF synchronizer.
  - A third register on sclk and on sen provides edge detection.
  - sclk_rise = synced 0->1; sclk_fall = synced 1->0; sen_rise and sen_fall likewise.
  - sdi is sampled in the same cycle sclk_rise is detected.
- Frame format: MSB first.
  - Bit 0 = R/W, 1 = read.
  - Bits 1-7 = address.
  - Bits 8-39 = data (write) or don't-care (read).
- A 6-bit bit counter increments on each sclk_rise while sen is high.
- FSM:
  - IDLE: on sen_rise, clear the counter and the 40-bit shift register, go to HDR, busy=1.
  - HDR: shift on sclk_rise. When the counter reaches 8:
    - Read flag set: load the output shift register with readback_[addr[1:0]] if addr < NUM_READBACK, else 0. Go to RDATA.
    - Otherwise go to WDATA.
  - WDATA: shift on sclk_rise. At counter == 40 go to FULL.
  - RDATA:
    - sdo_en=1 and sdo = output register MSB.
    - Shift the output register left on sclk_fall. The first fall after the load is the fall of bit 7 and does not shift.
    - At counter == 40 go to FULL.
  - FULL: further sclk_rise edges set an overrun flag; no shifting.
  - Any state other than IDLE, on sen_fall:
    - If state == FULL, the frame is a write, and no overrun: the next cycle loads serial_addr/serial_data and pulses serial_strobe for exactly 1 cycle.
    - A complete read frame returns silently.
    - Any other case (counter < 40, or overrun) pulses frame_error for 1 cycle with no strobe.
    - All cases return to IDLE; busy=0, sdo_en=0, sdo=0.
- Latency: serial_strobe asserts 4 master_clk cycles after the raw sen falling edge: 3 cycles for sync plus edge detect, 1 cycle to commit.
- serial_addr and serial_data hold their values between commits. They change only in the strobe cycle.
- sen_rise while not in IDLE is impossible by construction. A glitch of sen low for less than 3 cycles is filtered only if it is shorter than the sync window; otherwise it is treated as an aborted frame (frame_error).
- Read frames never generate serial_strobe.
- If reset_n asserts mid-frame: immediate return to IDLE, no strobe, no frame_error. The next frame starts cleanly on a fresh sen_rise. If sen is already high when reset_n releases, no frame starts until sen falls and rises again.

Test Plan:
- Write addr 0x05, data 0xDEADBEEF, SCLK = master_clk/16 -> exactly one serial_strobe with serial_addr=0x05 and serial_data=0xDEADBEEF, 4 cycles after sen falls; frame_error stays 0.
- Read addr 0x02 with readback_2=0x12345678 -> sdo_en high during bits 8-39; host samples 0x12345678 MSB first on SCLK rises; no strobe.
- Short write frame of 20 bits, then sen low -> frame_error pulse; serial_addr/serial_data unchanged from the previous value; no strobe.
- 41-bit write frame -> frame_error pulse, no strobe. Read of addr 0x7F -> sdo shifts 0x00000000.
- reset_n pulsed low at bit 25 of a write, then a full write of addr 0x01, data 0x00000003 -> first frame produces nothing; second strobes with 0x01/0x00000003.
- Two back-to-back write frames (sen low for 4 master_clk cycles between them), addresses 0x0A then 0x0B -> two strobes, in order, with correct data.
